// File: rtl/ram_banked.sv
// ram_banked: byte-addressed RAM built from WORD_BYTES byte-wide banks.
// Accepts byte/half/word requests at any alignment through a valid/ready
// port. An access that straddles a row boundary is split into a low part
// (at acceptance) and a high part (one cycle later). Responses are a
// single-cycle strobe with registered read data and an error flag.
module ram_banked #(
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32,
    parameter int SIZE_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [SIZE_W-1:0]       req_size,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [8*WORD_BYTES-1:0] rsp_rdata,
    output logic                    rsp_err
);

    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int CNT_W = OFF_W + 1;
    localparam int ROWS  = DEPTH_BYTES / WORD_BYTES;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW    = 8 * WORD_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Storage: one byte-wide array per bank, indexed by row.
    logic [7:0] mem_q [WORD_BYTES][ROWS];

    // Registered response.
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    // Request fields kept for the high half of a split access.
    logic [OFF_W-1:0] off_q;
    logic [CNT_W-1:0] nb_q;
    logic [ROW_W-1:0] row_hi_q;
    logic             write_q;
    logic [DW-1:0]    wdata_q;

    // Request decode.
    logic             accept;
    logic [OFF_W-1:0] req_off;
    logic [ROW_W-1:0] req_row;
    logic [CNT_W-1:0] req_nb;
    logic [ADDR_W:0]  req_end;
    logic             size_ok;
    logic             range_ok;
    logic             req_err;
    logic             req_split;

    // Per-bank control.
    logic [OFF_W-1:0] kr      [WORD_BYTES];
    logic [OFF_W-1:0] kq      [WORD_BYTES];
    logic             lo_sel  [WORD_BYTES];
    logic             hi_sel  [WORD_BYTES];
    logic [ROW_W-1:0] bank_row[WORD_BYTES];
    logic [7:0]       bank_rd [WORD_BYTES];
    logic             bank_we [WORD_BYTES];
    logic [7:0]       bank_wd [WORD_BYTES];

    assign req_ready = (state_q != ST_SPLIT);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    // Decode the incoming request: size, byte count, range and split checks.
    always_comb begin
        req_off   = req_addr[OFF_W-1:0];
        req_row   = req_addr[OFF_W +: ROW_W];
        req_nb    = CNT_W'(1) << req_size;
        size_ok   = (req_size <= SIZE_W'(OFF_W));
        req_end   = {1'b0, req_addr} + (ADDR_W+1)'(req_nb) - (ADDR_W+1)'(1);
        range_ok  = (req_end < (ADDR_W+1)'(DEPTH_BYTES));
        req_err   = !size_ok || !range_ok;
        req_split = ((CNT_W+1)'(req_off) + (CNT_W+1)'(req_nb)) > (CNT_W+1)'(WORD_BYTES);
    end

    // Bank addressing: which byte of the access each bank holds, and its row.
    // Banks at or above the start offset carry the low part (row R); banks
    // below it carry the high part (row R+1). The byte index wraps mod WORD_BYTES.
    always_comb begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            kr[b]       = OFF_W'(b) - req_off;
            kq[b]       = OFF_W'(b) - off_q;
            lo_sel[b]   = (OFF_W'(b) >= req_off) && ({1'b0, kr[b]} < req_nb);
            hi_sel[b]   = (OFF_W'(b) < off_q) && ({1'b0, kq[b]} < nb_q);
            bank_row[b] = (state_q == ST_SPLIT) ? row_hi_q : req_row;
            bank_rd[b]  = mem_q[b][bank_row[b]];
        end
    end

    // FSM next state, bank write strobes and response data assembly.
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        err_d   = 1'b0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            bank_we[b] = 1'b0;
            bank_wd[b] = '0;
        end

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        for (int b = 0; b < WORD_BYTES; b++) begin
                            if (lo_sel[b]) begin
                                bank_we[b] = req_write;
                                bank_wd[b] = req_wdata[8*kr[b] +: 8];
                                if (!req_write) begin
                                    rdata_d[8*kr[b] +: 8] = bank_rd[b];
                                end
                            end
                        end
                        state_d = req_split ? ST_SPLIT : ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPLIT: begin
                rdata_d = rdata_q;
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (hi_sel[b]) begin
                        bank_we[b] = write_q;
                        bank_wd[b] = wdata_q[8*kq[b] +: 8];
                        if (!write_q) begin
                            rdata_d[8*kq[b] +: 8] = bank_rd[b];
                        end
                    end
                end
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields needed to finish the high part of a split.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q    <= req_off;
            nb_q     <= req_nb;
            row_hi_q <= req_row + ROW_W'(1);
            write_q  <= req_write;
            wdata_q  <= req_wdata;
        end
    end

    // Bank writes; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (bank_we[b]) begin
                mem_q[b][bank_row[b]] <= bank_wd[b];
            end
        end
    end

endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: directed test of ram_banked with default parameters.
module tb_ram_banked;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          rlow;

    ram_banked #(
        .WORD_BYTES (4),
        .DEPTH_BYTES(1024),
        .ADDR_W     (32),
        .SIZE_W     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size (req_size),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    // lat counts edges from the accept edge to the first sample with rsp_valid.
    task automatic xact(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic ero,
                        output int lato, output int rlowo);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        lato  = 1;
        rlowo = 0;
        while (!rsp_valid && lato < 8) begin
            if (!req_ready) rlowo++;
            step();
            lato++;
        end
        if (!rsp_valid) lato = 99;
        rdo = rsp_rdata;
        ero = rsp_err;
        step();
        check_eq({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        step();
        step();
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_err",   {31'd0, rsp_err},   32'd0);
        check_eq("rst_rdata", rsp_rdata,          32'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a split word read at 0x3FB.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h3FB;
        step();
        req_valid = 1'b0;
        check_eq("split_busy", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("midrst_rdata", rsp_rdata,          32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("midrst_hold_valid", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("postrst_valid", {31'd0, rsp_valid}, 32'd0);
        end
        check_eq("postrst_ready", {31'd0, req_ready}, 32'd1);

        // Word write then word and byte reads.
        xact("ww58", 1'b1, 2'd2, 32'h58, 32'haabbccdd, rd, er, lat, rlow);
        check_eq("ww58_lat", lat, 1);
        check_eq("ww58_err", {31'd0, er}, 32'd0);
        check_eq("ww58_rdata", rd, 32'd0);
        xact("wr58", 1'b0, 2'd2, 32'h58, 32'h0, rd, er, lat, rlow);
        check_eq("wr58_lat", lat, 1);
        check_eq("wr58_rdata", rd, 32'haabbccdd);
        xact("br5a", 1'b0, 2'd0, 32'h5A, 32'h0, rd, er, lat, rlow);
        check_eq("br5a_rdata", rd, 32'h000000bb);

        // Split read across rows 0x58/0x5C.
        xact("bw5c", 1'b1, 2'd0, 32'h5C, 32'h11, rd, er, lat, rlow);
        check_eq("bw5c_lat", lat, 1);
        xact("wr59", 1'b0, 2'd2, 32'h59, 32'h0, rd, er, lat, rlow);
        check_eq("wr59_lat", lat, 2);
        check_eq("wr59_readylow", rlow, 1);
        check_eq("wr59_rdata", rd, 32'h11aabbcc);
        check_eq("wr59_err", {31'd0, er}, 32'd0);

        // Split write of a halfword at 0x5B.
        xact("hw5b", 1'b1, 2'd1, 32'h5B, 32'hbeef, rd, er, lat, rlow);
        check_eq("hw5b_lat", lat, 2);
        check_eq("hw5b_rdata", rd, 32'd0);
        xact("br5b", 1'b0, 2'd0, 32'h5B, 32'h0, rd, er, lat, rlow);
        check_eq("br5b_rdata", rd, 32'h000000ef);
        xact("br5c", 1'b0, 2'd0, 32'h5C, 32'h0, rd, er, lat, rlow);
        check_eq("br5c_rdata", rd, 32'h000000be);
        xact("wr58b", 1'b0, 2'd2, 32'h58, 32'h0, rd, er, lat, rlow);
        check_eq("wr58b_rdata", rd, 32'hefbbccdd);
        xact("hr5a", 1'b0, 2'd1, 32'h5A, 32'h0, rd, er, lat, rlow);
        check_eq("hr5a_rdata", rd, 32'h0000efbb);

        // Errors.
        xact("wr3fe", 1'b0, 2'd2, 32'h3FE, 32'h0, rd, er, lat, rlow);
        check_eq("wr3fe_err", {31'd0, er}, 32'd1);
        check_eq("wr3fe_rdata", rd, 32'd0);
        check_eq("wr3fe_lat", lat, 1);
        xact("sz3", 1'b0, 2'd3, 32'h0, 32'h0, rd, er, lat, rlow);
        check_eq("sz3_err", {31'd0, er}, 32'd1);
        check_eq("sz3_lat", lat, 1);
        xact("bw000", 1'b1, 2'd0, 32'h0, 32'h5a, rd, er, lat, rlow);
        check_eq("bw000_err", {31'd0, er}, 32'd0);
        xact("bw400", 1'b1, 2'd0, 32'h400, 32'hab, rd, er, lat, rlow);
        check_eq("bw400_err", {31'd0, er}, 32'd1);
        xact("br000", 1'b0, 2'd0, 32'h0, 32'h0, rd, er, lat, rlow);
        check_eq("br000_rdata", rd, 32'h0000005a);
        check_eq("br000_err", {31'd0, er}, 32'd0);

        // Back-to-back: four byte writes then a word read, valid held high.
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_write = (i < 4);
            req_size  = (i < 4) ? 2'd0 : 2'd2;
            req_addr  = (i < 4) ? 32'h10 + i : 32'h10;
            req_wdata = 32'(i + 1);
            step();
            check_eq("b2b_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("b2b_ready", {31'd0, req_ready}, 32'd1);
            if (i < 4) check_eq("b2b_wr_rdata", rsp_rdata, 32'd0);
        end
        check_eq("b2b_rdata", rsp_rdata, 32'h04030201);
        req_valid = 1'b0;
        step();
        check_eq("b2b_end_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("b2b_end_rdata", rsp_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
